rambus_arbiter: RTL
===================

Name: rambus_arbiter

Overview:
- Shares the single rambus RAM port between two requesters: the instruction-fetch unit (read-only) and the data RAM interface (loads and stores).
- Sits between the core's memory requesters and the RAM model.
- Accepts one transaction at a time and tracks the fixed RAM read latency.
- Routes read data back to the owning requester.
- Arbitration is data-priority, with an anti-starvation override for instruction fetch.

Parameters:
RD_LATENCY, 1, cycles from ram_re asserted to valid ram_rdata (legal range 1..15)
STARVE_LIMIT, 4, consecutive denied i_req cycles after which fetch wins the next arbitration (legal range 1..15)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  reset, asynchronous, active-low
i_req  in  1  fetch read request; held with i_addr stable until i_gnt
i_addr  in  32  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch read data valid (1-cycle pulse)
i_rdata  out  32  fetch read data
d_req  in  1  data request; held with d_* stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wstrb  in  4  store byte strobes
d_wdata  in  32  store data, already lane-shifted
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid (1-cycle pulse)
d_rdata  out  32  load data, raw word
ram_addr  out  32  to rambus
ram_re  out  1  to rambus
ram_we  out  1  to rambus
ram_wstrb  out  4  to rambus
ram_wdata  out  32  to rambus
ram_rdata  in  32  from rambus

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; latency counter, starvation counter and owner flag are cleared.
  - All outputs are 0.
  - A read in flight is dropped; no rvalid is produced for it after reset releases.
- FSM has two states, IDLE and WAIT.
- IDLE, arbitration is combinational in the same cycle:
  - if i_req and starve_cnt == STARVE_LIMIT, grant fetch;
  - else if d_req, grant data;
  - else if i_req, grant fetch;
  - else nothing.
  - The gnt output for the winner is high for exactly that cycle.
  - The ram_* outputs are driven from the winner in the grant cycle only; otherwise ram_re = ram_we = 0, ram_wstrb = 0, and ram_addr/ram_wdata = 0.
- Fetch grant:
  - ram_re=1, ram_addr=i_addr.
  - Go to WAIT with owner=I and cnt=RD_LATENCY-1.
- Data load grant:
  - ram_re=1, ram_addr=d_addr.
  - Go to WAIT with owner=D.
- Data store grant:
  - ram_we=1, ram_wstrb=d_wstrb, ram_wdata=d_wdata.
  - Store completes in the grant cycle; stay in IDLE. Back-to-back stores are possible every cycle.
- WAIT:
  - No grants are issued; ram_re and ram_we are held at 0.
  - cnt decrements each cycle until it reaches 0.
  - In the cycle with cnt==0, the owner's rvalid=1 and its rdata=ram_rdata (passthrough); the next state is IDLE.
  - Non-owner rvalid stays 0; both rdata outputs are 0 when their rvalid is low.
- Read timing: grant at cycle T, rvalid at cycle T+RD_LATENCY, earliest next grant at T+RD_LATENCY+1.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE cycle where i_req=1 and fetch is not granted.
  - Clears on fetch grant.
  - Holds during WAIT.
- Simultaneous i_req and d_req below the limit: data wins; fetch stays pending.
- Requests that arrive during WAIT are not granted. They must remain asserted and are arbitrated in the next IDLE cycle.
- A request dropped before its grant is treated as never issued (requester protocol violation, no error output).

Test Plan:
1. RD_LATENCY=2, fetch-only read, i_addr=0x100, RAM returns 0x00000013 → i_gnt at T, ram_re=1 with ram_addr=0x100 at T, i_rvalid=1 with i_rdata=0x13 at T+2, d_rvalid=0 throughout.
2. Simultaneous i_req and d_req (load, d_addr=0x200) in the same cycle → d_gnt first, d_rvalid at T+2, i_gnt at T+3, i_rvalid at T+5.
3. STARVE_LIMIT=4: d_req issues stores continuously while i_req is held → stores granted for 4 cycles, then i_gnt in cycle 5, starve_cnt back to 0; stores resume after i_rvalid.
4. Store d_wstrb=4'b0110, d_wdata=0x00ABCD00 → ram_we=1, ram_wstrb=0110, ram_wdata=0x00ABCD00 in the grant cycle only; no d_rvalid; a second store is granted in the next cycle.
5. rst_n pulled low one cycle after a fetch grant (RD_LATENCY=3) → all outputs 0 immediately, no i_rvalid after release, and a fresh i_req is granted in the first cycle after reset release.
6. RD_LATENCY=1 back-to-back loads → grants at T and T+2, rvalids at T+1 and T+3, ram_re never high in a WAIT cycle.

Source files
------------

// File: rtl/rambus_arbiter.sv
// Two-requester arbiter for the single rambus RAM port: data has priority,
// instruction fetch wins once it has been denied STARVE_LIMIT times in a row.
module rambus_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic       ST_IDLE    = 1'b0;
  localparam logic       ST_WAIT    = 1'b1;
  localparam logic       OWN_I      = 1'b0;
  localparam logic       OWN_D      = 1'b1;
  localparam logic [3:0] LAT_LOAD   = 4'(RD_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic       state, state_nxt;
  logic       owner, owner_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       arb_en, starved, grant_i, grant_d, rd_done;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign arb_en  = rst_n && (state == ST_IDLE);
  assign starved = (starve_cnt == STARVE_MAX);
  assign grant_i = arb_en && i_req && (starved || !d_req);
  assign grant_d = arb_en && d_req && !(i_req && starved);
  assign rd_done = (state == ST_WAIT) && (cnt == 4'd0);

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = rd_done && (owner == OWN_I);
  assign d_rvalid = rd_done && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? ram_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? ram_rdata : 32'd0;

  always_comb begin
    ram_re    = grant_i || (grant_d && !d_we);
    ram_we    = grant_d && d_we;
    ram_addr  = 32'd0;
    ram_wstrb = 4'd0;
    ram_wdata = 32'd0;
    if (grant_i) begin
      ram_addr = i_addr;
    end else if (grant_d) begin
      ram_addr = d_addr;
      if (d_we) begin
        ram_wstrb = d_wstrb;
        ram_wdata = d_wdata;
      end
    end
  end

  // Stores finish in their grant cycle; only reads occupy the port in WAIT.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    starve_nxt = starve_cnt;
    case (state)
      ST_IDLE: begin
        if (grant_i) begin
          state_nxt  = ST_WAIT;
          owner_nxt  = OWN_I;
          cnt_nxt    = LAT_LOAD;
          starve_nxt = 4'd0;
        end else begin
          if (grant_d && !d_we) begin
            state_nxt = ST_WAIT;
            owner_nxt = OWN_D;
            cnt_nxt   = LAT_LOAD;
          end
          if (i_req && !starved) begin
            starve_nxt = starve_cnt + 4'd1;
          end
        end
      end
      default: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      cnt        <= 4'd0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule
